// File: rtl/boot_rom_ctrl.sv
// Boot ROM overlay sequencer: round-robin CPU/DMA arbiter plus the sticky boot-disable register.
// Latency: ROM read acks two cycles after the grant cycle, every other access acks one cycle after it.
// Backpressure: one transaction in flight; a request held in IDLE waits until the block returns there.
module boot_rom_ctrl #(
   parameter logic [15:0] ROM_LAST     = 16'h00FF,
   parameter logic [15:0] DISABLE_ADDR = 16'hFF50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic        cpu_miss,
   output logic [7:0]  cpu_rdata,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   output logic        dma_ack,
   output logic        dma_miss,
   output logic [7:0]  dma_rdata,
   output logic        rom_en,
   output logic [7:0]  rom_addr,
   input  logic [7:0]  rom_data,
   output logic        boot_active
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

   state_t      state_q;
   logic        last_dma_q;     // most recently granted requester (1 = DMA)
   logic        gnt_dma_q;      // requester owning the current transaction
   logic        boot_active_q;
   logic        rom_en_q;
   logic [7:0]  rom_addr_q;
   logic        cpu_ack_q, cpu_miss_q;
   logic        dma_ack_q, dma_miss_q;
   logic [7:0]  rdata_q;        // register read data returned in DONE
   logic        rsp_rom_q;      // ack cycle carries ROM data straight through
   logic        clr_boot_q;     // DONE cycle of a disabling write

   logic        pick_dma;
   logic [15:0] sel_addr;
   logic        sel_we;
   logic        is_rom;
   logic        is_reg;
   logic        unused_wdata;

   // Only bit 0 of the write data has any meaning here.
   assign unused_wdata = ^cpu_wdata[7:1];

   // Grant selection and classification of the request seen in IDLE.
   always_comb begin
      pick_dma = dma_req && (!cpu_req || !last_dma_q);
      sel_addr = pick_dma ? dma_addr : cpu_addr;
      sel_we   = !pick_dma && cpu_we;
      is_rom   = !sel_we && (sel_addr <= ROM_LAST) && boot_active_q;
      is_reg   = !pick_dma && (sel_addr == DISABLE_ADDR);
   end

   // Main sequencer: grant, ROM issue, response and the sticky disable bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_dma_q    <= 1'b1;
         gnt_dma_q     <= 1'b0;
         boot_active_q <= 1'b1;
         rom_en_q      <= 1'b0;
         rom_addr_q    <= 8'h00;
         cpu_ack_q     <= 1'b0;
         cpu_miss_q    <= 1'b0;
         dma_ack_q     <= 1'b0;
         dma_miss_q    <= 1'b0;
         rdata_q       <= 8'h00;
         rsp_rom_q     <= 1'b0;
         clr_boot_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cpu_req || dma_req) begin
                  last_dma_q <= pick_dma;
                  gnt_dma_q  <= pick_dma;
                  if (is_rom) begin
                     state_q    <= ISSUE;
                     rom_en_q   <= 1'b1;
                     rom_addr_q <= sel_addr[7:0];
                  end else begin
                     // Non-ROM accesses answer directly from the DONE state.
                     state_q    <= DONE;
                     cpu_ack_q  <= !pick_dma;
                     cpu_miss_q <= !pick_dma && !is_reg;
                     dma_ack_q  <= pick_dma;
                     dma_miss_q <= pick_dma;
                     rdata_q    <= (is_reg && !sel_we) ? (boot_active_q ? 8'hFE : 8'hFF) : 8'h00;
                     clr_boot_q <= is_reg && sel_we && cpu_wdata[0];
                  end
               end
            end
            ISSUE: begin
               state_q   <= RESP;
               rom_en_q  <= 1'b0;
               cpu_ack_q <= !gnt_dma_q;
               dma_ack_q <= gnt_dma_q;
               rsp_rom_q <= 1'b1;
            end
            RESP: begin
               state_q   <= IDLE;
               cpu_ack_q <= 1'b0;
               dma_ack_q <= 1'b0;
               rsp_rom_q <= 1'b0;
            end
            DONE: begin
               state_q    <= IDLE;
               cpu_ack_q  <= 1'b0;
               cpu_miss_q <= 1'b0;
               dma_ack_q  <= 1'b0;
               dma_miss_q <= 1'b0;
               rdata_q    <= 8'h00;
               clr_boot_q <= 1'b0;
               if (clr_boot_q) begin
                  boot_active_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // ROM data is only valid in the ack cycle, so it bypasses the output register.
   always_comb begin
      cpu_rdata = 8'h00;
      dma_rdata = 8'h00;
      if (cpu_ack_q) begin
         cpu_rdata = rsp_rom_q ? rom_data : rdata_q;
      end
      if (dma_ack_q) begin
         dma_rdata = rsp_rom_q ? rom_data : rdata_q;
      end
   end

   assign cpu_ack     = cpu_ack_q;
   assign cpu_miss    = cpu_miss_q;
   assign dma_ack     = dma_ack_q;
   assign dma_miss    = dma_miss_q;
   assign rom_en      = rom_en_q;
   assign rom_addr    = rom_addr_q;
   assign boot_active = boot_active_q;

endmodule
